// File: rtl/control_pipe_if.sv
// Fetch-to-execute control interface: instruction handshake from fetch and
// the registered control bundle plus status toward the datapath.
interface control_pipe_if;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        flush_i;
    logic        stall_o;
    logic        ctrl_valid_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic        wr_regfile_o;
    logic        imm_sel_o;
    logic [1:0]  alu_sel_o;
    logic        mul_start_o;
    logic        mux2_alu_o;
    logic        wr_mem_o;
    logic        wb_sel_o;
    logic        branch_o;
    logic        jmp_o;
    logic        illegal_o;
    logic        mul_busy_o;

    // Fetch/stimulus side: drives instructions, observes the decoder.
    modport master (
        output instr_i, instr_valid_i, flush_i,
        input  stall_o, ctrl_valid_o, rs_o, rt_o, rd_o, wr_regfile_o,
               imm_sel_o, alu_sel_o, mul_start_o, mux2_alu_o, wr_mem_o,
               wb_sel_o, branch_o, jmp_o, illegal_o, mul_busy_o
    );

    // Decoder side.
    modport slave (
        input  instr_i, instr_valid_i, flush_i,
        output stall_o, ctrl_valid_o, rs_o, rt_o, rd_o, wr_regfile_o,
               imm_sel_o, alu_sel_o, mul_start_o, mux2_alu_o, wr_mem_o,
               wb_sel_o, branch_o, jmp_o, illegal_o, mul_busy_o
    );
endinterface

// File: rtl/control_pipe.sv
// Registered, hazard-aware instruction decoder. Decodes one instruction per
// cycle into a control bundle for execute, stalling fetch on load-use hazards
// and while a multi-cycle multiply is in flight; flushes on taken branch/jump.
module control_pipe #(
    parameter int MUL_LAT      = 4,
    parameter bit LOAD_USE_EN  = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    control_pipe_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JMP   = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd54;
    localparam logic [5:0] OP_SW    = 6'd55;
    localparam logic [5:0] OP_BNE   = 6'd56;
    localparam logic [5:0] OP_ADDI  = 6'd57;
    localparam logic [5:0] OP_ORI   = 6'd58;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Counter holds at most MUL_LAT-1; keep at least one bit for MUL_LAT=1.
    localparam int            CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       wr_regfile;
        logic       imm_sel;
        logic [1:0] alu_sel;
        logic       mul_start;
        logic       mux2_alu;
        logic       wr_mem;
        logic       wb_sel;
        logic       branch;
        logic       jmp;
    } ctrl_t;

    logic [5:0] op;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rdr_f;
    logic [5:0] funct;

    ctrl_t      dec;
    logic       legal;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_load;
    logic       is_mul;

    ctrl_t         ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    logic          load_q, load_d;
    logic          illegal_q, illegal_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic load_use;
    logic mul_busy;
    logic stall;
    logic accept;
    logic issue;

    assign op    = bus.instr_i[31:26];
    assign rs_f  = bus.instr_i[25:21];
    assign rt_f  = bus.instr_i[20:16];
    assign rdr_f = bus.instr_i[15:11];
    assign funct = bus.instr_i[5:0];

    // Shamt bits carry no meaning for this instruction set.
    logic unused_shamt;
    assign unused_shamt = &{1'b0, bus.instr_i[10:6]};

    // Decode the incoming instruction and classify which registers it reads.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves a variable unassigned, which would infer a latch.
        dec      = '0;
        legal    = 1'b1;
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        is_load  = 1'b0;
        is_mul   = 1'b0;
        dec.rs   = rs_f;
        dec.rt   = rt_f;
        unique case (op)
            OP_JMP: begin
                dec.rs       = '0;
                dec.rt       = '0;
                dec.jmp      = 1'b1;
                dec.mux2_alu = 1'b1;
                reads_rs     = 1'b0;
            end
            OP_LW: begin
                dec.rd         = rt_f;
                dec.wr_regfile = 1'b1;
                dec.imm_sel    = 1'b1;
                dec.alu_sel    = ALU_ADD;
                dec.mux2_alu   = 1'b1;
                is_load        = 1'b1;
            end
            OP_SW: begin
                dec.imm_sel  = 1'b1;
                dec.alu_sel  = ALU_ADD;
                dec.mux2_alu = 1'b1;
                dec.wr_mem   = 1'b1;
                reads_rt     = 1'b1;
            end
            OP_BNE: begin
                dec.alu_sel  = ALU_SUB;
                dec.mux2_alu = 1'b1;
                dec.branch   = 1'b1;
                reads_rt     = 1'b1;
            end
            OP_ADDI, OP_ORI: begin
                dec.rd         = rt_f;
                dec.wr_regfile = 1'b1;
                dec.imm_sel    = 1'b1;
                dec.alu_sel    = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                dec.mux2_alu   = 1'b1;
                dec.wb_sel     = 1'b1;
            end
            OP_RTYPE: begin
                dec.rd         = rdr_f;
                dec.wr_regfile = 1'b1;
                dec.wb_sel     = 1'b1;
                dec.mux2_alu   = 1'b1;
                reads_rt       = 1'b1;
                unique case (funct)
                    FN_ADD: dec.alu_sel = ALU_ADD;
                    FN_SUB: dec.alu_sel = ALU_SUB;
                    FN_AND: dec.alu_sel = ALU_AND;
                    FN_OR:  dec.alu_sel = ALU_OR;
                    FN_MUL: begin
                        dec.mul_start = 1'b1;
                        dec.mux2_alu  = 1'b0;
                        is_mul        = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // An undecodable word reads nothing and produces no control.
        if (!legal) begin
            dec      = '0;
            reads_rs = 1'b0;
            reads_rt = 1'b0;
            is_load  = 1'b0;
            is_mul   = 1'b0;
        end
    end

    // Hazard detection and the issue decision for this cycle.
    always_comb begin
        load_use = LOAD_USE_EN && load_q && (ctrl_q.rd != 5'd0) &&
                   ((reads_rs && (rs_f == ctrl_q.rd)) ||
                    (reads_rt && (rt_f == ctrl_q.rd)));
        mul_busy = (cnt_q != '0);
        stall    = bus.instr_valid_i && !bus.flush_i && (load_use || mul_busy);
        accept   = bus.instr_valid_i && !stall && !bus.flush_i;
        issue    = accept && legal;
    end

    // Next state: issued bundle or bubble, load tracking, trap, MUL countdown.
    always_comb begin
        ctrl_d    = issue ? dec : '0;
        valid_d   = issue;
        load_d    = issue && is_load;
        illegal_d = ILLEGAL_TRAP && accept && !legal;
        cnt_d     = cnt_q;
        if (issue && is_mul) begin
            cnt_d = MUL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pipeline register toward execute; cleared to a bubble on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            load_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            load_q    <= load_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.mul_busy_o   = mul_busy;
    assign bus.ctrl_valid_o = valid_q;
    assign bus.illegal_o    = illegal_q;
    assign bus.rs_o         = ctrl_q.rs;
    assign bus.rt_o         = ctrl_q.rt;
    assign bus.rd_o         = ctrl_q.rd;
    assign bus.wr_regfile_o = ctrl_q.wr_regfile;
    assign bus.imm_sel_o    = ctrl_q.imm_sel;
    assign bus.alu_sel_o    = ctrl_q.alu_sel;
    assign bus.mul_start_o  = ctrl_q.mul_start;
    assign bus.mux2_alu_o   = ctrl_q.mux2_alu;
    assign bus.wr_mem_o     = ctrl_q.wr_mem;
    assign bus.wb_sel_o     = ctrl_q.wb_sel;
    assign bus.branch_o     = ctrl_q.branch;
    assign bus.jmp_o        = ctrl_q.jmp;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe. dut_a uses the default configuration;
// dut_b shares its inputs with the load-use interlock off, the trap off and a
// single-cycle multiplier.
module tb_control_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    control_pipe_if bus_a ();
    control_pipe_if bus_b ();

    assign bus_b.instr_i       = bus_a.instr_i;
    assign bus_b.instr_valid_i = bus_a.instr_valid_i;
    assign bus_b.flush_i       = bus_a.flush_i;

    control_pipe #(.MUL_LAT(4), .LOAD_USE_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    control_pipe #(.MUL_LAT(1), .LOAD_USE_EN(1'b0), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    localparam logic [31:0] I_ADD   = 32'h0022_1820; // add r3,r1,r2
    localparam logic [31:0] I_ADD54 = 32'h0081_2820; // add r5,r4,r1
    localparam logic [31:0] I_ADD06 = 32'h0006_3820; // add r7,r0,r6
    localparam logic [31:0] I_LW    = 32'hD824_0000; // lw r4,0(r1)
    localparam logic [31:0] I_MUL   = 32'h0022_4032; // mul r8,r1,r2
    localparam logic [31:0] I_ORI   = 32'hE829_00FF; // ori r9,r1,0xff
    localparam logic [31:0] I_ILL63 = 32'hFC00_0000; // op 63
    localparam logic [31:0] I_ILLF7 = 32'h0000_0007; // op 0, funct 7

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic flush);
        bus_a.instr_i       = instr;
        bus_a.instr_valid_i = valid;
        bus_a.flush_i       = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view of dut_a's control bundle:
    // {rs, rt, rd, wr_regfile, imm, alu[1:0], mul_start, mux2, wr_mem, wb, branch, jmp}
    function automatic logic [31:0] bundle_a();
        return {7'd0, bus_a.rs_o, bus_a.rt_o, bus_a.rd_o, bus_a.wr_regfile_o,
                bus_a.imm_sel_o, bus_a.alu_sel_o, bus_a.mul_start_o,
                bus_a.mux2_alu_o, bus_a.wr_mem_o, bus_a.wb_sel_o,
                bus_a.branch_o, bus_a.jmp_o};
    endfunction

    function automatic logic [31:0] exp_bundle(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [9:0] flags);
        return {7'd0, rs, rt, rd, flags};
    endfunction

    // Decode vectors; flags = wr,imm,alu[1:0],mul,mux2,wr_mem,wb,branch,jmp
    logic [31:0] vec_instr [10];
    logic [31:0] vec_exp   [10];

    initial begin
        vec_instr[0] = 32'h0022_1820; vec_exp[0] = exp_bundle(5'd1, 5'd2, 5'd3, 10'b1_0_00_0_1_0_1_0_0); // ADD
        vec_instr[1] = 32'h0022_1822; vec_exp[1] = exp_bundle(5'd1, 5'd2, 5'd3, 10'b1_0_01_0_1_0_1_0_0); // SUB
        vec_instr[2] = 32'h0022_1824; vec_exp[2] = exp_bundle(5'd1, 5'd2, 5'd3, 10'b1_0_10_0_1_0_1_0_0); // AND
        vec_instr[3] = 32'h0022_1825; vec_exp[3] = exp_bundle(5'd1, 5'd2, 5'd3, 10'b1_0_11_0_1_0_1_0_0); // OR
        vec_instr[4] = 32'hE429_0005; vec_exp[4] = exp_bundle(5'd1, 5'd9, 5'd9, 10'b1_1_00_0_1_0_1_0_0); // ADDI
        vec_instr[5] = 32'hE829_00FF; vec_exp[5] = exp_bundle(5'd1, 5'd9, 5'd9, 10'b1_1_11_0_1_0_1_0_0); // ORI
        vec_instr[6] = 32'hDC25_0000; vec_exp[6] = exp_bundle(5'd1, 5'd5, 5'd0, 10'b0_1_00_0_1_1_0_0_0); // SW
        vec_instr[7] = 32'hE022_0000; vec_exp[7] = exp_bundle(5'd1, 5'd2, 5'd0, 10'b0_0_01_0_1_0_0_1_0); // BNE
        vec_instr[8] = 32'h0BFF_FFFF; vec_exp[8] = exp_bundle(5'd0, 5'd0, 5'd0, 10'b0_0_00_0_1_0_0_0_1); // JMP
        vec_instr[9] = 32'hD824_0000; vec_exp[9] = exp_bundle(5'd1, 5'd4, 5'd4, 10'b1_1_00_0_1_0_0_0_0); // LW
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(32'd0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset state.
        check("rst_valid",   32'(bus_a.ctrl_valid_o), 32'd0);
        check("rst_bundle",  bundle_a(),              32'd0);
        check("rst_stall",   32'(bus_a.stall_o),      32'd0);
        check("rst_busy",    32'(bus_a.mul_busy_o),   32'd0);
        check("rst_illegal", 32'(bus_a.illegal_o),    32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a multiply clears the counter at once.
        drive(I_MUL, 1'b1, 1'b0);
        check("mul_issue_stall", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("mul_bundle", bundle_a(), exp_bundle(5'd1, 5'd2, 5'd8, 10'b1_0_00_1_0_0_1_0_0));
        check("mul_valid",  32'(bus_a.ctrl_valid_o), 32'd1);
        check("mul_busy",   32'(bus_a.mul_busy_o),   32'd1);
        drive(32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  32'(bus_a.mul_busy_o),   32'd0);
        check("midrst_valid", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("midrst_mstart", 32'(bus_a.mul_start_o), 32'd0);
        tick();
        rst_n = 1'b1;

        // Latency-1 issue of ADD after reset, no leftover MUL stall.
        drive(I_ADD, 1'b1, 1'b0);
        check("add_stall", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("add_valid",  32'(bus_a.ctrl_valid_o), 32'd1);
        check("add_bundle", bundle_a(), exp_bundle(5'd1, 5'd2, 5'd3, 10'b1_0_00_0_1_0_1_0_0));

        // Decode table, back to back.
        for (int i = 0; i < 10; i++) begin
            drive(vec_instr[i], 1'b1, 1'b0);
            check($sformatf("dec%0d_stall", i), 32'(bus_a.stall_o), 32'd0);
            tick();
            check($sformatf("dec%0d_valid", i), 32'(bus_a.ctrl_valid_o), 32'd1);
            check($sformatf("dec%0d_bundle", i), bundle_a(), vec_exp[i]);
        end
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("idle_valid", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("idle_bundle", bundle_a(), 32'd0);

        // Load-use: LW r4 then ADD r5,r4,r1 -> one stall cycle, one bubble.
        drive(I_LW, 1'b1, 1'b0);
        tick();
        drive(I_ADD54, 1'b1, 1'b0);
        check("lu_stall",   32'(bus_a.stall_o), 32'd1);
        check("lu_b_stall", 32'(bus_b.stall_o), 32'd0);
        tick();
        check("lu_bubble", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("lu_bubble_rd", 32'(bus_a.rd_o), 32'd0);
        check("lu_clear", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("lu_issue_valid", 32'(bus_a.ctrl_valid_o), 32'd1);
        check("lu_issue_rs", 32'(bus_a.rs_o), 32'd4);
        check("lu_issue_rd", 32'(bus_a.rd_o), 32'd5);

        // LW r4 then ADD r7,r0,r6 -> no dependency, no stall.
        drive(I_LW, 1'b1, 1'b0);
        tick();
        drive(I_ADD06, 1'b1, 1'b0);
        check("nolu_stall", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("nolu_bundle", bundle_a(), exp_bundle(5'd0, 5'd6, 5'd7, 10'b1_0_00_0_1_0_1_0_0));

        // MUL then ORI: three stall cycles, ORI issues on the fourth edge.
        drive(I_MUL, 1'b1, 1'b0);
        tick();
        drive(I_ORI, 1'b1, 1'b0);
        check("mulb_busy", 32'(bus_b.mul_busy_o), 32'd0);
        check("mulb_stall", 32'(bus_b.stall_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mulst%0d_stall", i), 32'(bus_a.stall_o), 32'd1);
            check($sformatf("mulst%0d_busy", i), 32'(bus_a.mul_busy_o), 32'd1);
            tick();
            check($sformatf("mulst%0d_bubble", i), 32'(bus_a.ctrl_valid_o), 32'd0);
        end
        check("mulend_stall", 32'(bus_a.stall_o), 32'd0);
        check("mulend_busy", 32'(bus_a.mul_busy_o), 32'd0);
        tick();
        check("ori_valid", 32'(bus_a.ctrl_valid_o), 32'd1);
        check("ori_bundle", bundle_a(), exp_bundle(5'd1, 5'd9, 5'd9, 10'b1_1_11_0_1_0_1_0_0));

        // Flush during a MUL stall: bubble, no stall, counter keeps counting.
        drive(I_MUL, 1'b1, 1'b0);
        tick();
        drive(I_ADD, 1'b1, 1'b1);
        check("fl_stall", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("fl_bubble", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("fl_busy2", 32'(bus_a.mul_busy_o), 32'd1);
        drive(I_ADD, 1'b1, 1'b0);
        check("fl_restall", 32'(bus_a.stall_o), 32'd1);
        tick();
        check("fl_busy1", 32'(bus_a.mul_busy_o), 32'd1);
        tick();
        check("fl_busy0", 32'(bus_a.mul_busy_o), 32'd0);
        check("fl_stall0", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("fl_add_valid", 32'(bus_a.ctrl_valid_o), 32'd1);
        check("fl_add_rd", 32'(bus_a.rd_o), 32'd3);

        // Illegal instructions: bubble plus a one-cycle trap pulse.
        drive(I_ILL63, 1'b1, 1'b0);
        check("ill63_stall", 32'(bus_a.stall_o), 32'd0);
        tick();
        check("ill63_pulse", 32'(bus_a.illegal_o), 32'd1);
        check("ill63_valid", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("ill63_bundle", bundle_a(), 32'd0);
        check("ill63_b_pulse", 32'(bus_b.illegal_o), 32'd0);
        drive(I_ILLF7, 1'b1, 1'b0);
        tick();
        check("illf7_pulse", 32'(bus_a.illegal_o), 32'd1);
        check("illf7_valid", 32'(bus_a.ctrl_valid_o), 32'd0);
        check("illf7_b_pulse", 32'(bus_b.illegal_o), 32'd0);
        drive(32'd0, 1'b0, 1'b0);
        tick();
        check("ill_end", 32'(bus_a.illegal_o), 32'd0);

        // Flush takes precedence over the trap.
        drive(I_ILL63, 1'b1, 1'b1);
        tick();
        check("ill_flush", 32'(bus_a.illegal_o), 32'd0);
        drive(32'd0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
Registered, hazard-aware successor to the combinational CPU control decoder. Decodes one 32-bit instruction per cycle into a registered control bundle for the execute stage. Adds a valid/stall handshake toward fetch, a load-use interlock, a structural stall for a multi-cycle multiplier, flush on taken branch/jump, and illegal-opcode detection. Sits between instruction fetch and the register file/ALU/multiplier datapath.

Parameters:
MUL_LAT, 4, multiplier latency in cycles (>=1); issue blocked for MUL_LAT-1 cycles after a MUL.
LOAD_USE_EN, 1, 1 = load-use interlock enabled; 0 = no load-use stall.
ILLEGAL_TRAP, 1, 1 = pulse illegal_o on an undecodable instruction; 0 = drop it silently.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction word; held stable by fetch while stall_o=1
instr_valid_i  in  1  instr_i is valid
flush_i  in  1  taken branch/jump; discard current instruction
stall_o  out  1  combinational; fetch must hold instr_i
ctrl_valid_o  out  1  control bundle valid (0 = bubble)
rs_o, rt_o, rd_o  out  5 each  register indices
wr_regfile_o  out  1  register-file write enable
imm_sel_o  out  1  ALU B = immediate
alu_sel_o  out  2  00 add, 01 sub, 10 and, 11 or
mul_start_o  out  1  start multiplier
mux2_alu_o  out  1  1 = ALU result, 0 = multiplier result
wr_mem_o  out  1  data-memory write
wb_sel_o  out  1  1 = ALU/MUL writeback, 0 = memory writeback
branch_o, jmp_o  out  1 each  BNE / JMP flags
illegal_o  out  1  one-cycle illegal-instruction pulse
mul_busy_o  out  1  multiplier in flight

Behaviour:
- Reset: every output 0; MUL counter 0; previous-load tracking cleared. Asynchronous assert, synchronous release.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rdR=[15:11], funct=[5:0].
  - JMP op 2: jmp=1, mux2=1, rs/rt/rd=0.
  - LW op 54: rd=rt, wr_regfile=1, imm=1, alu=00, mux2=1, wb=0.
  - SW op 55: rd=0, imm=1, alu=00, mux2=1, wr_mem=1.
  - BNE op 56: rd=0, alu=01, mux2=1, branch=1.
  - ADDI op 57 / ORI op 58: rd=rt, wr_regfile=1, imm=1, alu=00/11, mux2=1, wb=1.
  - R-type op 0, rd=rdR, wr_regfile=1, wb=1:
    - ADD funct 32: alu=00, mux2=1.
    - SUB funct 34: alu=01, mux2=1.
    - AND funct 36: alu=10, mux2=1, mul_start=0.
    - OR funct 37: alu=11, mux2=1, mul_start=0.
    - MUL funct 50: mul_start=1, mux2=0.
  - Any other op, or op 0 with any other funct: illegal.
- Unlisted control bits are 0. A bubble drives ctrl_valid_o=0 and every control field 0.
- Accept: instruction is issued at a rising edge when instr_valid_i=1, stall_o=0 and flush_i=0. Its bundle appears on the outputs after that edge (latency 1) with ctrl_valid_o=1. Otherwise a bubble is registered.
- Load-use (LOAD_USE_EN=1): stall_o=1 when the registered bundle is a valid LW with rd_o!=0 and the incoming instruction reads rd_o.
  - rs is read by all instructions except JMP.
  - rt is read by R-type, SW and BNE.
  - Exactly one bubble is inserted; the stall clears the next cycle.
- MUL: issuing a MUL loads the counter with MUL_LAT-1. mul_busy_o = (counter!=0); the counter decrements each cycle while nonzero. stall_o=1 while the counter is nonzero and instr_valid_i=1, for any instruction. With MUL_LAT=1 there is never a stall.
- stall_o = instr_valid_i & !flush_i & (load_use | mul_busy).
- flush_i=1 at an edge: registers a bubble and drops the instruction; flush overrides stall. The MUL counter keeps counting, since the in-flight multiply completes.
- Illegal: a bubble is registered. If ILLEGAL_TRAP=1, illegal_o=1 for that one cycle. Stall and flush take precedence, so illegal_o fires only when the instruction would otherwise have been accepted.
- instr_valid_i=0: bubble, stall_o=0.

Test Plan:
- Reset mid-MUL: issue MUL, assert rst_n=0 after 1 cycle -> all outputs 0, mul_busy_o=0 immediately; after release, ADD issues with no stall.
- Latency: ADD r3,r1,r2 (0x00221820) -> next cycle ctrl_valid_o=1, rd_o=3, alu_sel_o=00, wr_regfile_o=1, wb_sel_o=1, mux2_alu_o=1.
- Load-use: LW r4 (op 54, rt=4), then ADD r5,r4,r1 -> stall_o=1 one cycle, one bubble, then ADD issues with rs_o=4. Same sequence with ADD rs=r0/rt=r6 -> no stall.
- MUL stall, MUL_LAT=4: MUL then ORI -> stall_o=1 for 3 cycles, mul_busy_o=1 for 3 cycles, ORI issues on the 4th cycle with alu_sel_o=11, imm_sel_o=1.
- Flush during MUL stall: flush_i=1 -> bubble, stall_o=0 that cycle, counter still decrements to 0 on schedule.
- Illegal: op 63, then op 0 with funct 7 -> two bubbles, illegal_o pulses 1 cycle each with ILLEGAL_TRAP=1; stays 0 with ILLEGAL_TRAP=0.
